// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch front end: next-PC select codes, PC sequencer states
// and default reset/exception addresses.
package cpu_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JR     = 3'd3,
        NPC_EXC    = 3'd4,
        NPC_ERET   = 3'd5
    } npc_sel_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

endpackage

// File: rtl/pc_next_reg_npc_mux.sv
// Combinational next-PC target selection, branch adder and jr/eret alignment check.
// PC_EXC_EN enables exc/eret selects and trap-on-misalign; otherwise targets are force-aligned.
module npc_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc,
    input  logic [2:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [31:0] jump_target,
    input  logic [31:0] rs_data,
    input  logic [31:0] epc,
    output logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        redirect,
    output logic        is_exc,
    output logic        misalign
);

    logic [31:0] br_off;
    logic [31:0] raw_target;
    logic        chk_align;
    logic        raw_misalign;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        raw_target = pc_plus4;
        redirect   = 1'b0;
        chk_align  = 1'b0;
        case (npc_sel_t'(npc_sel))
            NPC_BRANCH: begin
                // An untaken branch is an ordinary sequential step, not a redirect.
                if (branch_taken) begin
                    raw_target = pc_plus4 + br_off;
                    redirect   = 1'b1;
                end
            end
            NPC_JUMP: begin
                raw_target = jump_target;
                redirect   = 1'b1;
            end
            NPC_JR: begin
                raw_target = rs_data;
                redirect   = 1'b1;
                chk_align  = 1'b1;
            end
`ifdef PC_EXC_EN
            NPC_EXC: begin
                raw_target = EXC_VECTOR;
                redirect   = 1'b1;
            end
            NPC_ERET: begin
                raw_target = epc;
                redirect   = 1'b1;
                chk_align  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign raw_misalign = chk_align && (raw_target[1:0] != 2'b00);

`ifdef PC_EXC_EN
    assign target   = raw_misalign ? EXC_VECTOR : raw_target;
    assign misalign = raw_misalign;
    assign is_exc   = (npc_sel == NPC_EXC);
`else
    logic unused_ok;
    assign unused_ok = ^{epc, raw_misalign, EXC_VECTOR};
    assign target    = {raw_target[31:2], 2'b00};
    assign misalign  = 1'b0;
    assign is_exc    = 1'b0;
`endif

endmodule

// File: rtl/pc_next_reg.sv
// Architectural PC register with BOOT/RUN/HOLD sequencing and a one-entry redirect buffer
// for redirects arriving under stall. PC_EXC_EN enables exception/ERET targets.
module pc_next_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [2:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [31:0] jump_target,
    input  logic [31:0] rs_data,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [3:0]  pc_hi,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic        misalign_err
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_mis_q, pend_mis_d;
    logic        mis_q, mis_d;

    logic [31:0] target;
    logic        redirect;
    logic        is_exc;
    logic        misalign;

    npc_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_mux (
        .pc           (pc_q),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jump_target  (jump_target),
        .rs_data      (rs_data),
        .epc          (epc),
        .pc_plus4     (pc_plus4),
        .target       (target),
        .redirect     (redirect),
        .is_exc       (is_exc),
        .misalign     (misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_mis_d = pend_mis_q;
        mis_d      = 1'b0;
        case (state_q)
            BOOT: begin
                pc_d    = RESET_PC;
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    pc_d  = target;
                    mis_d = misalign;
                end else if (redirect) begin
                    pend_d     = target;
                    pend_mis_d = misalign;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // First redirect wins, except that an exception always takes over the slot.
                if (!stall) begin
                    pc_d    = pend_q;
                    mis_d   = pend_mis_q;
                    state_d = RUN;
                end else if (is_exc) begin
                    pend_d     = EXC_VECTOR;
                    pend_mis_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 32'd0;
            pend_mis_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_mis_q <= pend_mis_d;
            mis_q      <= mis_d;
        end
    end

    assign pc               = pc_q;
    assign pc_hi            = pc_q[31:28];
    assign fetch_valid      = (state_q == RUN);
    assign redirect_pending = (state_q == HOLD);
    assign misalign_err     = mis_q;

endmodule

// File: tb/tb_pc_next_reg.sv
// Scoreboard bench for pc_next_reg: directed test-plan sequences then random traffic,
// each checked against a behavioural model of the PC sequencing rules.
module tb_pc_next_reg;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC = 32'h0040_0004;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  npc_sel;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [31:0] jump_target;
    logic [31:0] rs_data;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_hi;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misalign_err;

    pc_next_reg #(
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_VEC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .npc_sel          (npc_sel),
        .branch_taken     (branch_taken),
        .imm16            (imm16),
        .jump_target      (jump_target),
        .rs_data          (rs_data),
        .epc              (epc),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .pc_hi            (pc_hi),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        rp;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: what the PC unit has architecturally committed to.
    bit          m_boot     = 1'b1;
    logic [31:0] m_pc       = RST_PC;
    bit          m_pend     = 1'b0;
    logic [31:0] m_pend_tgt = 32'd0;
    bit          m_pend_mis = 1'b0;
    bit          m_mis      = 1'b0;

    function automatic void resolve(input logic [2:0] s, input logic tk, input logic [15:0] im,
                                    input logic [31:0] jt, input logic [31:0] rs,
                                    input logic [31:0] ep, input logic [31:0] cur,
                                    output bit redir, output logic [31:0] t, output bit mis);
        int off;
        bit chk;
        off   = $signed(im);
        redir = 1'b1;
        mis   = 1'b0;
        chk   = 1'b0;
        if (s == 3'd1 && tk)      t = cur + 32'd4 + 32'(off * 4);
        else if (s == 3'd2)       t = jt;
        else if (s == 3'd3)       begin t = rs; chk = 1'b1; end
`ifdef PC_EXC_EN
        else if (s == 3'd4)       t = EXC_VEC;
        else if (s == 3'd5)       begin t = ep; chk = 1'b1; end
`endif
        else                      begin t = cur + 32'd4; redir = 1'b0; end
        if (chk && t[1:0] != 2'b00) begin
`ifdef PC_EXC_EN
            t   = EXC_VEC;
            mis = 1'b1;
`else
            t[1:0] = 2'b00;
`endif
        end
    endfunction

    task automatic drive(input logic rn, input logic st, input logic [2:0] s, input logic tk,
                         input logic [15:0] im, input logic [31:0] jt, input logic [31:0] rs,
                         input logic [31:0] ep);
        bit          redir;
        logic [31:0] t;
        bit          tmis;
        exp_t        e;
        rst_n = rn; stall = st; npc_sel = s; branch_taken = tk;
        imm16 = im; jump_target = jt; rs_data = rs; epc = ep;
        resolve(s, tk, im, jt, rs, ep, m_pc, redir, t, tmis);
        if (!rn) begin
            m_boot = 1'b1; m_pc = RST_PC; m_pend = 1'b0; m_pend_tgt = 32'd0;
            m_pend_mis = 1'b0; m_mis = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_mis = 1'b0;
        end else if (m_pend) begin
            m_mis = 1'b0;
            if (!st) begin
                m_pc = m_pend_tgt; m_mis = m_pend_mis; m_pend = 1'b0;
            end
`ifdef PC_EXC_EN
            else if (s == 3'd4) begin
                m_pend_tgt = EXC_VEC; m_pend_mis = 1'b0;
            end
`endif
        end else begin
            m_mis = 1'b0;
            if (!st) begin
                m_pc = t; m_mis = tmis;
            end else if (redir) begin
                m_pend = 1'b1; m_pend_tgt = t; m_pend_mis = tmis;
            end
        end
        e.pc  = m_pc;
        e.fv  = !m_boot && !m_pend;
        e.rp  = m_pend;
        e.mis = m_mis;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic go(input logic st, input logic [2:0] s, input logic [31:0] jt);
        drive(1'b1, st, s, 1'b0, 16'h0000, jt, 32'h0040_0000, 32'h0040_0000);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every clock edge yields one observable PC-unit state.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("pc_hi", {28'd0, pc_hi}, {28'd0, e.pc[31:28]});
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
            chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.rp});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        end
    end

    initial begin
        // Reset, then sequential fetch from the reset vector.
        drive(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) go(1'b0, 3'd0, 32'h0);
        // Backward taken branch, then untaken branch.
        go(1'b0, 3'd2, 32'h0040_0010);
        drive(1'b1, 1'b0, 3'd1, 1'b1, 16'hFFFC, 32'h0, 32'h0, 32'h0);
        go(1'b0, 3'd2, 32'h0040_0010);
        drive(1'b1, 1'b0, 3'd1, 1'b0, 16'hFFFC, 32'h0, 32'h0, 32'h0);
        // Jump captured under a 3-cycle stall; a seq select on release is ignored.
        go(1'b0, 3'd2, 32'h0040_0020);
        repeat (3) go(1'b1, 3'd2, 32'h0040_0100);
        go(1'b0, 3'd0, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        // Pending jump overridden by an exception select while stalled.
        go(1'b1, 3'd2, 32'h0040_0200);
        go(1'b1, 3'd4, 32'h0);
        go(1'b1, 3'd2, 32'h0040_0300);
        go(1'b0, 3'd2, 32'h0040_0400);
        go(1'b0, 3'd0, 32'h0);
        // Misaligned jr, aligned jr, misaligned eret.
        drive(1'b1, 1'b0, 3'd3, 1'b0, 16'h0, 32'h0, 32'h0040_0102, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        drive(1'b1, 1'b0, 3'd3, 1'b0, 16'h0, 32'h0, 32'h0040_0800, 32'h0);
        drive(1'b1, 1'b0, 3'd5, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0040_0903);
        // Misaligned jr captured under stall reports on release.
        drive(1'b1, 1'b1, 3'd3, 1'b0, 16'h0, 32'h0, 32'h0040_0A01, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        // Wrap at the top of the address space.
        go(1'b0, 3'd2, 32'hFFFF_FFFC);
        go(1'b0, 3'd0, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        // Reset during HOLD drops the pending redirect.
        go(1'b1, 3'd2, 32'h0040_0500);
        drive(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 32'h0040_0500, 32'h0, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        go(1'b0, 3'd0, 32'h0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            logic [31:0] ep;
            rs = $urandom();
            ep = $urandom();
            if ($urandom_range(0, 3) != 0) rs = rs & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) ep = ep & 32'hFFFF_FFFC;
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  16'($urandom()), $urandom() & 32'hFFFF_FFFC, rs, ep);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_next_reg.md
# pc_next_reg

Program-counter register and next-PC selector for the single-cycle MIPS core. Holds the architectural PC, computes PC+4 and the branch target, and selects among sequential, branch, J/JAL, JR/JALR, exception and ERET targets. Exports `pc[31:28]` to the jump-target concatenation stage and takes the finished 32-bit jump target back, so it sits directly downstream of that stage. A one-entry redirect buffer holds a redirect that arrives while the core is stalled.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.
- `EXC_VECTOR`, default 32'h0040_0004: exception entry address.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold PC this cycle.
- `npc_sel`  in  3  target select: 0 seq, 1 branch, 2 jump, 3 jr, 4 exc, 5 eret; 6–7 treated as seq.
- `branch_taken`  in  1  qualifies `npc_sel`=1; if 0, sequential.
- `imm16`  in  16  branch offset, in words.
- `jump_target`  in  32  concatenated J/JAL target from the upstream stage.
- `rs_data`  in  32  JR/JALR target.
- `epc`  in  32  ERET target.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  pc+4, combinational, also the link value.
- `pc_hi`  out  4  `pc[31:28]`, to the jump-target stage.
- `fetch_valid`  out  1  instruction at `pc` is to be committed.
- `redirect_pending`  out  1  buffered redirect held.
- `misalign_err`  out  1  one-cycle pulse on a misaligned jr/eret target.

## Operation
- Target arithmetic, all modulo 2^32 with silent wrap:
  - seq: `pc+4`.
  - branch: `pc+4 + {{14{imm16[15]}},imm16,2'b00}`.
  - jump: `jump_target`.
  - jr: `rs_data`.
  - eret: `epc`.
  - exc: `EXC_VECTOR`.
- States:
  - BOOT: entered on reset. `pc` = `RESET_PC`, `fetch_valid`=0, inputs ignored. Next state is RUN unconditionally.
  - RUN: `fetch_valid`=1.
    - `stall`=0: pc ← selected target.
    - `stall`=1 with non-seq select: target captured into the pending register, pc held, go to HOLD.
    - `stall`=1 with seq select: pc held.
  - HOLD: `redirect_pending`=1, `fetch_valid`=0.
    - `stall`=1: pc held. A new exc select overwrites the pending target with `EXC_VECTOR`. Any other new select is ignored (first redirect wins).
    - `stall`=0: pc ← pending target, go to RUN. Current `npc_sel` is ignored that cycle.
- Misalign: a jr/eret target with `[1:0]` ≠ 0 raises `misalign_err` for one cycle on the update edge (behaviour per Configuration). Jump and branch targets are aligned by construction.
- Reset values: `pc`=`RESET_PC`, pending register = 0, `redirect_pending`=0, `misalign_err`=0, `fetch_valid`=0, state BOOT.

## Timing
- PC update on the rising edge. The new target is visible on `pc` one cycle after select.
- `pc_plus4` and `pc_hi` are combinational from `pc`; the jump-target stage output returns in the same cycle.
- `misalign_err` is registered and asserts in the cycle the new `pc` appears.
- Reset asserted mid-HOLD: the pending redirect is discarded and the block enters BOOT next cycle.
- `pc`=32'hFFFF_FFFC with seq selected → 32'h0000_0000, no error.

## Configuration
- `PC_EXC_EN` defined:
  - exc/eret selects are active.
  - Misaligned jr/eret redirects to `EXC_VECTOR` and pulses `misalign_err`.
- `PC_EXC_EN` undefined:
  - `epc` is unused; selects 4/5 are treated as seq.
  - A misaligned target is force-aligned (`[1:0]` cleared) and `misalign_err` is tied to 0.

## Structure
- Shared package `cpu_pkg`: `npc_sel` encoding enum (NPC_SEQ…NPC_ERET), state enum (BOOT/RUN/HOLD), default `RESET_PC`/`EXC_VECTOR` constants.
- One sub-module: `npc_mux`, purely combinational. It does the target selection, branch adder and misalign check. The state machine and registers stay in `pc_next_reg`.

## Test plan
- Reset held 2 cycles, released, seq select:
  - `pc`=0x00400000 with `fetch_valid`=0 for one cycle.
  - Then 0x00400000 with `fetch_valid`=1, then 0x00400004.
- `pc`=0x00400010, branch, `branch_taken`=1, `imm16`=16'hFFFC → next `pc`=0x00400004. Same with `branch_taken`=0 → 0x00400014.
- `pc`=0x00400020, jump with `jump_target`=0x00400100 while `stall`=1 for 3 cycles:
  - `pc` held, `redirect_pending`=1.
  - After `stall` falls, next `pc`=0x00400100.
- In HOLD with a pending jump, exc select while stalled → after release `pc`=0x00400004.
- jr with `rs_data`=0x00400102:
  - With `PC_EXC_EN`: `pc`=0x00400004 and a 1-cycle `misalign_err`.
  - Without: `pc`=0x00400100 and `misalign_err`=0.
- `pc`=0xFFFFFFFC with seq select → `pc`=0x00000000.
